// File: rtl/fx_pkg.sv
// Shared types, reset defaults and helpers for the effects chain.
package fx_pkg;

  typedef enum logic [1:0] {
    FX_BYPASS = 2'd0,
    FX_HARD   = 2'd1,
    FX_SOFT   = 2'd2
  } clip_mode_e;

  typedef enum logic {
    PAR_IDLE    = 1'b0,
    PAR_PENDING = 1'b1
  } par_state_e;

  localparam clip_mode_e FX_DEF_MODE = FX_BYPASS;

  // Raw mode code 3 is an alias for bypass.
  function automatic clip_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return FX_HARD;
      2'd2:    return FX_SOFT;
      default: return FX_BYPASS;
    endcase
  endfunction

  // Clamp a signed value into the range of a signed w-bit word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (w - 1));
    if (v > maxv)      return maxv;
    else if (v < minv) return minv;
    else               return v;
  endfunction

endpackage

// File: rtl/fx_mul_shift_sat.sv
// Combinational signed*unsigned multiply, floor shift by FRAC, saturate to OUT_W.
module fx_mul_shift_sat
  import fx_pkg::*;
#(
  parameter int unsigned A_W   = 24,
  parameter int unsigned B_W   = 11,
  parameter int unsigned FRAC  = 4,
  parameter int unsigned OUT_W = 24
) (
  input  logic signed [A_W-1:0]   i_a,
  input  logic        [B_W-1:0]   i_b,
  output logic signed [OUT_W-1:0] o_y
);

  localparam int unsigned P_W = A_W + B_W + 1;

  logic signed [P_W-1:0] w_a;
  logic signed [P_W-1:0] w_b;
  logic signed [P_W-1:0] w_prod;
  logic signed [P_W-1:0] w_shift;

  assign w_a     = P_W'(i_a);
  assign w_b     = {{(P_W-B_W){1'b0}}, i_b};
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> FRAC;
  assign o_y     = OUT_W'(sat_signed(64'(w_shift), OUT_W));

endmodule

// File: rtl/fx_chain_pipeline.sv
// Gain -> clipper -> level pipeline, 4-cycle latency, double-buffered parameters.
module fx_chain_pipeline
  import fx_pkg::*;
#(
  parameter int unsigned IN_W       = 12,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned INT_W      = 24,
  parameter int unsigned GAIN_W     = 11,
  parameter int unsigned GAIN_FRAC  = 4,
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned LEVEL_FRAC = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [IN_W-1:0]  i_sample,
  input  logic                    i_par_load,
  input  logic [GAIN_W-1:0]       i_par_gain,
  input  logic [1:0]              i_par_mode,
  input  logic [OUT_W-2:0]        i_par_thr,
  input  logic [LEVEL_W-1:0]      i_par_level,
  input  logic                    i_clr_stats,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_par_pending,
  output logic [15:0]             o_clip_cnt
);

  localparam logic [GAIN_W-1:0]  DEF_GAIN  = GAIN_W'(1 << GAIN_FRAC);
  localparam logic [LEVEL_W-1:0] DEF_LEVEL = LEVEL_W'(1 << LEVEL_FRAC);

  par_state_e          r_state;
  logic [GAIN_W-1:0]   r_sh_gain,  r_act_gain;
  clip_mode_e          r_sh_mode,  r_act_mode;
  logic [OUT_W-2:0]    r_sh_thr,   r_act_thr;
  logic [LEVEL_W-1:0]  r_sh_level, r_act_level;

  logic                    r_s0_v, r_s1_v, r_s2_v;
  logic signed [INT_W-1:0] r_s0_x, r_s1_x, r_s2_x;

  logic signed [INT_W-1:0] w_s1_d;
  logic signed [INT_W-1:0] w_s2_d;
  logic signed [OUT_W-1:0] w_s3_d;
  logic [INT_W-1:0]        w_abs, w_thr, w_soft_mag;
  logic                    w_neg, w_over, w_clip_evt, w_pipe_empty;

  assign w_pipe_empty  = !i_valid && !r_s0_v && !r_s1_v && !r_s2_v && !o_valid;
  assign o_par_pending = (r_state == PAR_PENDING);

  fx_mul_shift_sat #(.A_W(INT_W), .B_W(GAIN_W), .FRAC(GAIN_FRAC), .OUT_W(INT_W)) u_gain (
    .i_a(r_s0_x), .i_b(r_act_gain), .o_y(w_s1_d)
  );

  fx_mul_shift_sat #(.A_W(INT_W), .B_W(LEVEL_W), .FRAC(LEVEL_FRAC), .OUT_W(OUT_W)) u_level (
    .i_a(r_s2_x), .i_b(r_act_level), .o_y(w_s3_d)
  );

  // Clipper transfer function and clip-event detect for stage 2.
  always_comb begin
    w_neg      = r_s1_x[INT_W-1];
    w_abs      = w_neg ? (-r_s1_x) : r_s1_x;
    w_thr      = INT_W'(r_act_thr);
    w_over     = w_abs > w_thr;
    w_soft_mag = w_thr + ((w_abs - w_thr) >> 2);
    w_s2_d     = r_s1_x;
    w_clip_evt = 1'b0;
    case (r_act_mode)
      FX_HARD: if (w_over) begin
        w_s2_d     = w_neg ? -$signed(w_thr) : $signed(w_thr);
        w_clip_evt = 1'b1;
      end
      FX_SOFT: if (w_over) begin
        w_s2_d     = w_neg ? -$signed(w_soft_mag) : $signed(w_soft_mag);
        w_clip_evt = 1'b1;
      end
      default: ;
    endcase
  end

  // Pipeline stages: data registers load only on incoming valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_v   <= 1'b0;
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      o_valid  <= 1'b0;
      r_s0_x   <= '0;
      r_s1_x   <= '0;
      r_s2_x   <= '0;
      o_sample <= '0;
    end else begin
      r_s0_v  <= i_valid;
      r_s1_v  <= r_s0_v;
      r_s2_v  <= r_s1_v;
      o_valid <= r_s2_v;
      if (i_valid) r_s0_x   <= INT_W'(i_sample);
      if (r_s0_v)  r_s1_x   <= w_s1_d;
      if (r_s1_v)  r_s2_x   <= w_s2_d;
      if (r_s2_v)  o_sample <= w_s3_d;
    end
  end

  // Parameter FSM: capture into shadow, promote to active only when the pipe is empty.
  // A load in the empty cycle takes priority, so its values wait for the next empty cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PAR_IDLE;
      r_sh_gain   <= DEF_GAIN;
      r_sh_mode   <= FX_DEF_MODE;
      r_sh_thr    <= '1;
      r_sh_level  <= DEF_LEVEL;
      r_act_gain  <= DEF_GAIN;
      r_act_mode  <= FX_DEF_MODE;
      r_act_thr   <= '1;
      r_act_level <= DEF_LEVEL;
    end else if (i_par_load) begin
      r_state    <= PAR_PENDING;
      r_sh_gain  <= i_par_gain;
      r_sh_mode  <= decode_mode(i_par_mode);
      r_sh_thr   <= i_par_thr;
      r_sh_level <= i_par_level;
    end else if (r_state == PAR_PENDING && w_pipe_empty) begin
      r_state     <= PAR_IDLE;
      r_act_gain  <= r_sh_gain;
      r_act_mode  <= r_sh_mode;
      r_act_thr   <= r_sh_thr;
      r_act_level <= r_sh_level;
    end
  end

  // Saturating clip-event counter; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       o_clip_cnt <= '0;
    else if (i_clr_stats)                          o_clip_cnt <= '0;
    else if (r_s1_v && w_clip_evt && o_clip_cnt != '1) o_clip_cnt <= o_clip_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fx_chain_pipeline.sv
// Directed self-checking bench for fx_chain_pipeline.
module tb_fx_chain_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [11:0] i_sample;
  logic        i_par_load;
  logic [10:0] i_par_gain;
  logic [1:0]  i_par_mode;
  logic [14:0] i_par_thr;
  logic [7:0]  i_par_level;
  logic        i_clr_stats;
  logic        o_valid;
  logic [15:0] o_sample;
  logic        o_par_pending;
  logic [15:0] o_clip_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fx_chain_pipeline #(
    .IN_W(12), .OUT_W(16), .INT_W(24), .GAIN_W(11),
    .GAIN_FRAC(4), .LEVEL_W(8), .LEVEL_FRAC(7)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sample(i_sample),
    .i_par_load(i_par_load), .i_par_gain(i_par_gain), .i_par_mode(i_par_mode),
    .i_par_thr(i_par_thr), .i_par_level(i_par_level), .i_clr_stats(i_clr_stats),
    .o_valid(o_valid), .o_sample(o_sample), .o_par_pending(o_par_pending),
    .o_clip_cnt(o_clip_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load parameters from an empty pipe; pending must be seen, then cleared by the swap.
  task automatic load_params(input string tag, input logic [10:0] g, input logic [1:0] m,
                             input logic [14:0] t, input logic [7:0] l);
    @(negedge clk);
    i_par_load = 1'b1; i_par_gain = g; i_par_mode = m; i_par_thr = t; i_par_level = l;
    @(negedge clk);
    i_par_load = 1'b0;
    check({tag, "_pend1"}, 32'(o_par_pending), 32'd1);
    @(negedge clk);
    check({tag, "_pend0"}, 32'(o_par_pending), 32'd0);
  endtask

  // Two back-to-back samples; outputs must arrive exactly 4 and 5 cycles later.
  task automatic run_pair(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [15:0] ea, input logic [15:0] eb);
    @(negedge clk); i_valid = 1'b1; i_sample = a;
    @(negedge clk); i_sample = b;
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk); check({tag, "_v_early"}, 32'(o_valid), 32'd0);
    @(negedge clk); check({tag, "_v_a"}, 32'(o_valid), 32'd1);
                    check({tag, "_a"}, 32'(o_sample), 32'(ea));
    @(negedge clk); check({tag, "_v_b"}, 32'(o_valid), 32'd1);
                    check({tag, "_b"}, 32'(o_sample), 32'(eb));
    @(negedge clk); check({tag, "_v_end"}, 32'(o_valid), 32'd0);
                    check({tag, "_hold"}, 32'(o_sample), 32'(eb));
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_sample = '0; i_par_load = 1'b0; i_par_gain = '0;
    i_par_mode = '0; i_par_thr = '0; i_par_level = '0; i_clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_sample", 32'(o_sample), 32'd0);
    check("rst_pend", 32'(o_par_pending), 32'd0);
    check("rst_cnt", 32'(o_clip_cnt), 32'd0);
    rst = 1'b0;

    // Reset mid-stream drops in-flight samples.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); i_valid = 1'b1; i_sample = 12'd5;
    end
    @(negedge clk); i_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("midrst_valid", 32'(o_valid), 32'd0);
    end
    check("midrst_sample", 32'(o_sample), 32'd0);
    check("midrst_cnt", 32'(o_clip_cnt), 32'd0);

    // Unity defaults.
    run_pair("unity", 12'h7FF, 12'h800, 16'h07FF, 16'hF800);

    // Hard clip, x10 gain, thr 4000.
    load_params("hard_ld", 11'd160, 2'd1, 15'd4000, 8'd128);
    run_pair("hard", 12'd1000, 12'hC18, 16'h0FA0, 16'hF060);
    check("hard_cnt", 32'(o_clip_cnt), 32'd2);

    // Soft knee: 10000 -> 4000 + 6000/4 = 5500; 3000 under threshold.
    load_params("soft_ld", 11'd160, 2'd2, 15'd4000, 8'd128);
    run_pair("soft", 12'd1000, 12'd300, 16'h157C, 16'h0BB8);
    check("soft_cnt", 32'(o_clip_cnt), 32'd3);

    // Parameter swap deferred while a sample is in flight.
    load_params("swap_base", 11'd16, 2'd0, 15'h7FFF, 8'd128);
    @(negedge clk); i_valid = 1'b1; i_sample = 12'd100;
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk); i_par_load = 1'b1; i_par_gain = 11'd32;
    @(negedge clk); i_par_load = 1'b0;
                    check("swap_pend_a", 32'(o_par_pending), 32'd1);
    @(negedge clk); check("swap_old_v", 32'(o_valid), 32'd1);
                    check("swap_old_s", 32'(o_sample), 32'd100);
                    check("swap_pend_b", 32'(o_par_pending), 32'd1);
    @(negedge clk); check("swap_pend_c", 32'(o_par_pending), 32'd1);
    @(negedge clk); check("swap_pend_d", 32'(o_par_pending), 32'd0);
    run_pair("swap_new", 12'd100, 12'hF9C, 16'h00C8, 16'hFF38);

    // Output saturation.
    load_params("sat_ld", 11'd2047, 2'd0, 15'h7FFF, 8'd255);
    run_pair("sat", 12'h7FF, 12'h800, 16'h7FFF, 16'h8000);

    // Counter saturation: every sample of 1 clips against thr 0.
    load_params("cnt_ld", 11'd16, 2'd1, 15'd0, 8'd128);
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk); i_valid = 1'b1; i_sample = 12'd1;
    end
    @(negedge clk); i_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("cnt_sat", 32'(o_clip_cnt), 32'hFFFF);

    // Clear coincides with a clip event and wins; later events count from zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); i_valid = 1'b1; i_sample = 12'd1;
      i_clr_stats = (i == 2);
      if (i == 3) check("cnt_clr", 32'(o_clip_cnt), 32'd0);
    end
    @(negedge clk); i_valid = 1'b0; i_clr_stats = 1'b0;
    repeat (6) @(negedge clk);
    check("cnt_after_clr", 32'(o_clip_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
